car_sequencer: RTL and testbench

Microprogram sequencer that owns the Control Address Register (CAR) driving the microcode ROM. It sits directly downstream of the CAR decoder: at each instruction boundary it loads the decoder's start address for the instruction word, then steps through microcode by increment, unconditional jump, or conditional jump. It also arbitrates interrupt entry and holds on memory stalls.

---
 rtl/car_seq_if.sv | 28 ++
 rtl/car_sequencer.sv | 127 ++++++++++++
 tb/tb_car_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/car_seq_if.sv
// Bus between the microcode control path and the CAR sequencer.
// The master drives the decoder and microword fields; the slave returns the CAR and status.
interface car_seq_if #(
    parameter int unsigned CAR_BITS = 6
);
    logic [CAR_BITS-1:0] car_dec;
    logic                iw_valid;
    logic [1:0]          u_ctl;
    logic [CAR_BITS-1:0] u_next;
    logic                cond;
    logic                stall;
    logic                irq;
    logic [CAR_BITS-1:0] car;
    logic                ir_load;
    logic                int_ack;
    logic                waiting;
    logic [3:0]          step;

    modport master (
        output car_dec, iw_valid, u_ctl, u_next, cond, stall, irq,
        input  car, ir_load, int_ack, waiting, step
    );

    modport slave (
        input  car_dec, iw_valid, u_ctl, u_next, cond, stall, irq,
        output car, ir_load, int_ack, waiting, step
    );
endinterface

// File: rtl/car_sequencer.sv
// Microprogram sequencer owning the Control Address Register.
// It steps microcode by INC/JUMP/COND and dispatches to a new instruction or interrupt entry.
module car_sequencer #(
    parameter int unsigned         CAR_BITS  = 6,
    parameter logic [CAR_BITS-1:0] RESET_CAR = '0,
    parameter logic [CAR_BITS-1:0] INT_CAR   = 6'd62
) (
    input  logic      MCLK,
    input  logic      RST,
    car_seq_if.slave  bus
);
    localparam int unsigned STEP_BITS = 4;
    localparam logic [STEP_BITS-1:0] STEP_MAX = '1;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        U_INC  = 2'b00,
        U_JUMP = 2'b01,
        U_COND = 2'b10,
        U_DISP = 2'b11
    } uctl_e;

    state_e               state_q, state_d;
    logic [CAR_BITS-1:0]  car_q, car_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic                 ir_load_q, ir_load_d;
    logic                 int_ack_q, int_ack_d;
    logic                 waiting_q, waiting_d;

    logic [CAR_BITS-1:0]  car_inc_c;
    logic [STEP_BITS-1:0] step_inc_c;
    logic                 disp_ok_c;

    assign car_inc_c  = CAR_BITS'(car_q + CAR_BITS'(1));
    assign step_inc_c = (step_q == STEP_MAX) ? step_q : STEP_BITS'(step_q + STEP_BITS'(1));
    assign disp_ok_c  = bus.irq | bus.iw_valid;

    // Next-state, next-CAR and strobe decode
    always_comb begin
        state_d   = state_q;
        car_d     = car_q;
        step_d    = step_q;
        ir_load_d = 1'b0;
        int_ack_d = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                car_d   = RESET_CAR;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall) begin
                    unique case (uctl_e'(bus.u_ctl))
                        U_INC: begin
                            car_d  = car_inc_c;
                            step_d = step_inc_c;
                        end
                        U_JUMP: begin
                            car_d  = bus.u_next;
                            step_d = step_inc_c;
                        end
                        U_COND: begin
                            car_d  = bus.cond ? bus.u_next : car_inc_c;
                            step_d = step_inc_c;
                        end
                        U_DISP: begin
                            if (!disp_ok_c) state_d = S_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                if (disp_ok_c) state_d = S_RUN;
            end
            default: begin
                state_d = S_BOOT;
                car_d   = RESET_CAR;
            end
        endcase

        // Shared dispatch resolution: interrupt beats a ready instruction word
        if (((state_q == S_RUN) && !bus.stall && (uctl_e'(bus.u_ctl) == U_DISP))
            || (state_q == S_WAIT)) begin
            if (bus.irq) begin
                car_d     = INT_CAR;
                int_ack_d = 1'b1;
                step_d    = '0;
            end else if (bus.iw_valid) begin
                car_d     = bus.car_dec;
                ir_load_d = 1'b1;
                step_d    = '0;
            end
        end

        waiting_d = (state_d == S_WAIT);
    end

    always_ff @(posedge MCLK) begin
        if (!RST) begin
            state_q   <= S_BOOT;
            car_q     <= RESET_CAR;
            step_q    <= '0;
            ir_load_q <= 1'b0;
            int_ack_q <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            car_q     <= car_d;
            step_q    <= step_d;
            ir_load_q <= ir_load_d;
            int_ack_q <= int_ack_d;
            waiting_q <= waiting_d;
        end
    end

    assign bus.car     = car_q;
    assign bus.step    = step_q;
    assign bus.ir_load = ir_load_q;
    assign bus.int_ack = int_ack_q;
    assign bus.waiting = waiting_q;
endmodule

// File: tb/tb_car_sequencer.sv
// Scoreboard bench for car_sequencer: directed vectors queue hand-computed
// expectations; a monitor compares them one cycle at a time after each edge.
module tb_car_sequencer;
    localparam int unsigned CAR_BITS = 6;
    localparam logic [1:0] INC = 2'b00, JMP = 2'b01, CND = 2'b10, DSP = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    car_seq_if #(.CAR_BITS(CAR_BITS)) bus ();

    car_sequencer #(.CAR_BITS(CAR_BITS)) dut (
        .MCLK (clk),
        .RST  (rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] car;
        logic       ir_load;
        logic       int_ack;
        logic       waiting;
        logic [3:0] step;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic vec(input string name, input logic rst, input logic [1:0] ctl,
                       input logic [5:0] nxt, input logic cnd, input logic stl,
                       input logic irq, input logic iwv, input logic [5:0] dec,
                       input logic [5:0] e_car, input logic e_irl, input logic e_ack,
                       input logic e_wait, input logic [3:0] e_step);
        exp_t e;
        @(negedge clk);
        rst_n        = rst;
        bus.u_ctl    = ctl;
        bus.u_next   = nxt;
        bus.cond     = cnd;
        bus.stall    = stl;
        bus.irq      = irq;
        bus.iw_valid = iwv;
        bus.car_dec  = dec;
        e.name = name; e.car = e_car; e.ir_load = e_irl; e.int_ack = e_ack;
        e.waiting = e_wait; e.step = e_step;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every edge presents a new output word; compare against the head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.car !== e.car || bus.ir_load !== e.ir_load || bus.int_ack !== e.int_ack ||
                    bus.waiting !== e.waiting || bus.step !== e.step) begin
                    n_miss++;
                    $display("FAIL %s: got car=%0d irl=%b ack=%b wait=%b step=%0d, want car=%0d irl=%b ack=%b wait=%b step=%0d",
                             e.name, bus.car, bus.ir_load, bus.int_ack, bus.waiting, bus.step,
                             e.car, e.ir_load, e.int_ack, e.waiting, e.step);
                end
            end
        end
    end

    initial begin
        bus.u_ctl = INC; bus.u_next = '0; bus.cond = 1'b0; bus.stall = 1'b0;
        bus.irq = 1'b0; bus.iw_valid = 1'b0; bus.car_dec = '0;

        // Reset held, then boot: CAR 0 for two cycles, then counting
        for (int i = 0; i < 3; i++) vec("reset", 0, INC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("boot",  1, INC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("run1",  1, INC, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vec("run2",  1, INC, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2);
        vec("run3",  1, INC, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 3);

        // Dispatch with instruction word ready
        vec("disp_iw",  1, DSP, 0, 0, 0, 0, 1, 17, 17, 1, 0, 0, 0);
        vec("post_iw",  1, INC, 0, 0, 0, 0, 0, 0,  18, 0, 0, 0, 1);

        // Wait path: three idle cycles, then instruction word arrives
        for (int i = 0; i < 3; i++) vec("wait", 1, DSP, 0, 0, 0, 0, 0, 0, 18, 0, 0, 1, 1);
        vec("wait_iw",  1, DSP, 0, 0, 0, 0, 1, 9, 9, 1, 0, 0, 0);

        // Interrupt beats instruction word
        vec("irq_prio", 1, DSP, 0, 0, 0, 1, 1, 5, 62, 0, 1, 0, 0);
        vec("inc63",    1, INC, 0, 0, 0, 0, 0, 0, 63, 0, 0, 0, 1);
        vec("wrap",     1, INC, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
        vec("jump40",   1, JMP, 40, 0, 0, 0, 0, 0, 40, 0, 0, 0, 3);
        vec("cond0",    1, CND, 20, 0, 0, 0, 0, 0, 41, 0, 0, 0, 4);
        vec("cond1",    1, CND, 20, 1, 0, 0, 0, 0, 20, 0, 0, 0, 5);

        // Stall freezes a jump, then a dispatch
        vec("stall_j1", 1, JMP, 50, 0, 1, 0, 0, 0, 20, 0, 0, 0, 5);
        vec("stall_j2", 1, JMP, 50, 0, 1, 0, 0, 0, 20, 0, 0, 0, 5);
        vec("jump50",   1, JMP, 50, 0, 0, 0, 0, 0, 50, 0, 0, 0, 6);
        vec("stall_dp", 1, DSP, 0, 0, 1, 1, 1, 7, 50, 0, 0, 0, 6);
        vec("to_wait",  1, DSP, 0, 0, 0, 0, 0, 0, 50, 0, 0, 1, 6);
        vec("wait_stl", 1, DSP, 0, 0, 1, 0, 0, 0, 50, 0, 0, 1, 6);

        // Reset from S_WAIT, then S_BOOT holds CAR one more cycle
        vec("rst_wait", 0, DSP, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0);
        vec("boot2",    1, INC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("run_b2",   1, INC, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

        // STEP saturates at 15
        for (int k = 1; k <= 16; k++)
            vec("step_sat", 1, INC, 0, 0, 0, 0, 0, 0, 6'(1 + k), 0, 0, 0, (k >= 14) ? 4'd15 : 4'(1 + k));

        // Interrupt accepted from S_WAIT
        vec("wait_irq0", 1, DSP, 0, 0, 0, 0, 0, 0, 17, 0, 0, 1, 15);
        vec("wait_irq1", 1, DSP, 0, 0, 0, 1, 0, 0, 62, 0, 1, 0, 0);
        vec("post_irq",  1, JMP, 33, 0, 0, 0, 0, 0, 33, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
